// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the lock-in muxer scan sequencer.
// Channel geometry, FSM states and small configuration helpers.
package mux_scan_pkg;

   localparam int unsigned NCH  = 16;
   localparam int unsigned SELW = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DWELL
   } state_t;

   // A programmed dwell of zero still takes one sample.
   function automatic int unsigned dwell_clamp(input int unsigned len);
      return (len == 0) ? 1 : len;
   endfunction

   function automatic logic [SELW-1:0] first_set(input logic [NCH-1:0] m);
      logic [SELW-1:0] idx;
      idx = '0;
      for (int unsigned i = NCH; i > 0; i--) begin
         if (m[SELW'(i - 1)]) begin
            idx = SELW'(i - 1);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_scan_ctrl_next_chan_find.sv
// Next enabled channel strictly above the current one, wrapping to the
// lowest enabled channel; wrap flags that the scan pass has completed.
module next_chan_find
   import mux_scan_pkg::*;
(
   input  logic [NCH-1:0]  mask,
   input  logic [SELW-1:0] cur,
   output logic [SELW-1:0] nxt,
   output logic            wrap
);

   logic [SELW-1:0] lo_idx;
   logic [SELW-1:0] hi_idx;
   logic            hi_found;

   // Descending sweep: the last hit is the lowest qualifying index.
   always_comb begin
      lo_idx   = '0;
      hi_idx   = '0;
      hi_found = 1'b0;
      for (int unsigned i = NCH; i > 0; i--) begin
         if (mask[SELW'(i - 1)]) begin
            lo_idx = SELW'(i - 1);
            if (SELW'(i - 1) > cur) begin
               hi_idx   = SELW'(i - 1);
               hi_found = 1'b1;
            end
         end
      end
      nxt  = hi_found ? hi_idx : lo_idx;
      wrap = ~hi_found;
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 16:1 lock-in muxer: settle, dwell-accumulate and
// emit one tagged sum per channel visit, single-shot or continuous.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned RES = 14,
   parameter int unsigned DW  = 16,
   parameter int unsigned SW  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        continuous,
   input  logic [NCH-1:0]              ch_mask,
   input  logic [SW-1:0]               settle_len,
   input  logic [DW-1:0]               dwell_len,
   input  logic signed [RES-1:0]       din,
   output logic [SELW-1:0]             sel,
   output logic                        busy,
   output logic signed [RES+DW-1:0]    acc_out,
   output logic                        acc_valid,
   output logic [SELW-1:0]             acc_ch,
   output logic                        scan_done
);

   localparam int unsigned AW = RES + DW;
   localparam int unsigned CW = (SW > DW) ? SW : DW;

   state_t            state;
   state_t            state_nx;

   logic [NCH-1:0]    mask_lat;
   logic [SW-1:0]     settle_lat;
   logic [DW-1:0]     dwell_lat;
   logic              cont_lat;
   logic [CW-1:0]     cnt;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] din_sx;

   logic              go;
   logic              emit;
   logic              settle_last;
   logic              dwell_last;
   logic [SELW-1:0]   nxt_ch;
   logic              nxt_wrap;

   assign din_sx = {{DW{din[RES-1]}}, din};
   assign busy   = (state != IDLE);

   // settle_len of 0 and 1 both leave a single blanking cycle after the switch.
   assign settle_last = (({1'b0, cnt} + (CW+1)'(1)) >= (CW+1)'(settle_lat));
   assign dwell_last  = (cnt == CW'(dwell_lat - DW'(1)));

   next_chan_find u_next (
      .mask (mask_lat),
      .cur  (sel),
      .nxt  (nxt_ch),
      .wrap (nxt_wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      go       = 1'b0;
      emit     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !stop && (ch_mask != '0)) begin
               go       = 1'b1;
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            if (stop) begin
               state_nx = IDLE;
            end else if (settle_last) begin
               state_nx = DWELL;
            end
         end
         DWELL: begin
            if (stop) begin
               state_nx = IDLE;
            end else if (dwell_last) begin
               emit     = 1'b1;
               state_nx = (nxt_wrap && !cont_lat) ? IDLE : SETTLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_lat   <= '0;
         settle_lat <= '0;
         dwell_lat  <= '0;
         cont_lat   <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         sel        <= '0;
         acc_out    <= '0;
         acc_valid  <= 1'b0;
         acc_ch     <= '0;
         scan_done  <= 1'b0;
      end else begin
         acc_valid <= emit;
         scan_done <= emit && nxt_wrap;

         if ((state_nx != state) || (state == IDLE)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end

         if (go) begin
            mask_lat   <= ch_mask;
            settle_lat <= settle_len;
            dwell_lat  <= DW'(dwell_clamp(32'(dwell_len)));
            cont_lat   <= continuous;
            sel        <= first_set(ch_mask);
         end

         // The final sample bypasses acc so the strobe carries the complete sum.
         if (emit) begin
            acc_out <= acc + din_sx;
            acc_ch  <= sel;
            if (!(nxt_wrap && !cont_lat)) begin
               sel <= nxt_ch;
            end
         end

         if (state_nx == SETTLE) begin
            acc <= '0;
         end else if (state == DWELL) begin
            acc <= acc + din_sx;
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scenarios plus random
// scans, checked every cycle against a visit-position reference model.
module tb_mux_scan_ctrl;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               stop;
   logic               continuous;
   logic [15:0]        ch_mask;
   logic [7:0]         settle_len;
   logic [15:0]        dwell_len;
   logic signed [13:0] din;
   logic [3:0]         sel;
   logic               busy;
   logic signed [29:0] acc_out;
   logic               acc_valid;
   logic [3:0]         acc_ch;
   logic               scan_done;

   mux_scan_ctrl #(.RES(14), .DW(16), .SW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .ch_mask    (ch_mask),
      .settle_len (settle_len),
      .dwell_len  (dwell_len),
      .din        (din),
      .sel        (sel),
      .busy       (busy),
      .acc_out    (acc_out),
      .acc_valid  (acc_valid),
      .acc_ch     (acc_ch),
      .scan_done  (scan_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: visit position counted from the channel switch
   bit          m_active;
   int          m_ch, m_pos, m_settle, m_dwell, m_och;
   bit          m_cont, m_valid, m_done;
   logic [15:0] m_mask;
   longint      m_sum, m_out;

   int                 din_mode;
   logic signed [13:0] din_fixed;
   logic signed [13:0] chan_val [16];

   longint q_ch[$];
   longint q_sum[$];
   longint q_done[$];
   longint q_sel[$];
   int     sel_last;

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint q_get(input longint q[$], input int i);
      return (i < q.size()) ? q[i] : -999;
   endfunction

   task automatic model_reset();
      m_active = 0; m_ch = 0; m_pos = 0; m_sum = 0; m_out = 0; m_och = 0;
      m_valid = 0; m_done = 0; m_mask = '0; m_settle = 0; m_dwell = 1; m_cont = 0;
   endtask

   task automatic model_step();
      int s_eff, nx, idx;
      bit found;
      m_valid = 0;
      m_done  = 0;
      if (!m_active) begin
         if (start && !stop && ch_mask != 0) begin
            m_mask   = ch_mask;
            m_settle = settle_len;
            m_dwell  = (dwell_len == 0) ? 1 : dwell_len;
            m_cont   = continuous;
            m_active = 1;
            m_pos    = 0;
            m_sum    = 0;
            for (int i = 15; i >= 0; i--)
               if (((ch_mask >> i) & 16'd1) != 16'd0) m_ch = i;
         end
      end else if (stop) begin
         m_active = 0;
      end else begin
         s_eff = (m_settle == 0) ? 1 : m_settle;
         if (m_pos >= s_eff) m_sum += din;
         m_pos++;
         if (m_pos == s_eff + m_dwell) begin
            nx = m_ch;
            found = 0;
            for (int d = 1; d <= 16; d++) begin
               idx = (m_ch + d) % 16;
               if (!found && ((m_mask >> idx) & 16'd1) != 16'd0) begin
                  nx = idx;
                  found = 1;
               end
            end
            m_valid = 1;
            m_out   = m_sum;
            m_och   = m_ch;
            m_done  = (nx <= m_ch);
            if (m_done && !m_cont) m_active = 0;
            else m_ch = nx;
            m_pos = 0;
            m_sum = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("sel", sel, m_ch);
      check("busy", busy, m_active);
      check("acc_valid", acc_valid, m_valid);
      check("scan_done", scan_done, m_done);
      check("acc_out", acc_out, m_out);
      check("acc_ch", acc_ch, m_och);
   endtask

   task automatic cyc();
      case (din_mode)
         0:       din = din_fixed;
         1:       din = chan_val[sel];
         default: din = 14'($urandom);
      endcase
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      if (acc_valid) begin
         q_ch.push_back(acc_ch);
         q_sum.push_back(acc_out);
         q_done.push_back(scan_done);
      end
      if (sel != sel_last) begin
         q_sel.push_back(sel);
         sel_last = sel;
      end
   endtask

   task automatic clear_q();
      q_ch.delete(); q_sum.delete(); q_done.delete(); q_sel.delete();
      sel_last = -1;
   endtask

   task automatic cfg(input logic [15:0] m, input int s, input int d, input bit c);
      ch_mask = m; settle_len = 8'(s); dwell_len = 16'(d); continuous = c;
   endtask

   task automatic pulse_start();
      start = 1;
      cyc();
      start = 0;
   endtask

   task automatic halt();
      stop = 1;
      cyc();
      stop = 0;
   endtask

   task automatic run_until_idle(input int limit);
      int n = 0;
      while (m_active && n < limit) begin
         cyc();
         n++;
      end
      check("idle_reached", busy, 0);
   endtask

   initial begin
      longint exp_sel [5];
      int n, ndone;

      rst = 1; start = 0; stop = 0; din_mode = 0; din_fixed = '0; din = '0;
      cfg(16'h0000, 0, 0, 0);
      for (int i = 0; i < 16; i++) chan_val[i] = 14'($urandom);
      model_reset();
      clear_q();
      repeat (3) @(posedge clk);
      #1;
      check("rst_sel", sel, 0);
      check("rst_busy", busy, 0);
      check("rst_acc_out", acc_out, 0);
      check("rst_acc_valid", acc_valid, 0);
      check("rst_acc_ch", acc_ch, 0);
      check("rst_scan_done", scan_done, 0);
      rst = 0;
      repeat (2) cyc();

      // basic single pass
      chan_val[0] = 14'sd3;
      chan_val[2] = -14'sd5;
      din_mode = 1;
      cfg(16'h0005, 2, 4, 0);
      clear_q();
      pulse_start();
      run_until_idle(40);
      check("basic_count", q_ch.size(), 2);
      check("basic_ch0", q_get(q_ch, 0), 0);
      check("basic_sum0", q_get(q_sum, 0), 12);
      check("basic_done0", q_get(q_done, 0), 0);
      check("basic_ch1", q_get(q_ch, 1), 2);
      check("basic_sum1", q_get(q_sum, 1), -20);
      check("basic_done1", q_get(q_done, 1), 1);
      check("basic_sel_end", sel, 2);
      repeat (2) cyc();

      // zero settle / zero dwell, single channel
      din_mode = 2;
      cfg(16'h8000, 0, 0, 1);
      clear_q();
      pulse_start();
      repeat (20) cyc();
      ndone = 0;
      foreach (q_done[i]) ndone += int'(q_done[i]);
      check("zero_strobes", q_ch.size(), 10);
      check("zero_dones", ndone, 10);
      check("zero_ch", q_get(q_ch, 9), 15);
      halt();

      // wrap order
      cfg(16'h8421, 1, 2, 1);
      clear_q();
      pulse_start();
      repeat (13) cyc();
      exp_sel = '{0, 5, 10, 15, 0};
      for (int i = 0; i < 5; i++) check("wrap_sel", q_get(q_sel, i), exp_sel[i]);
      for (int i = 0; i < 4; i++) check("wrap_done", q_get(q_done, i), (i == 3) ? 1 : 0);
      halt();

      // stop in the 2nd dwell cycle of the second channel
      cfg(16'h0050, 1, 4, 1);
      clear_q();
      pulse_start();
      n = 0;
      while (!(m_active && m_ch == 6 && m_pos == 2) && n < 40) begin
         cyc();
         n++;
      end
      check("stop_window_found", n < 40, 1);
      halt();
      check("stop_busy", busy, 0);
      check("stop_sel", sel, 6);
      check("stop_strobes", q_ch.size(), 1);
      check("stop_ch", q_get(q_ch, 0), 4);
      repeat (3) cyc();
      pulse_start();
      check("restart_sel", sel, 4);
      check("restart_busy", busy, 1);
      halt();

      // ignored starts: empty mask, then pulses while busy
      cfg(16'h0000, 1, 1, 1);
      start = 1;
      repeat (3) cyc();
      start = 0;
      check("empty_mask_busy", busy, 0);
      cfg(16'h0003, 2, 3, 0);
      clear_q();
      pulse_start();
      for (int i = 0; i < 9; i++) begin
         start = (i % 3 == 2);
         cfg(16'($urandom), $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom));
         cyc();
      end
      start = 0;
      run_until_idle(30);
      check("busy_start_count", q_ch.size(), 2);
      check("busy_start_ch0", q_get(q_ch, 0), 0);
      check("busy_start_ch1", q_get(q_ch, 1), 1);

      // random scans
      for (int it = 0; it < 30; it++) begin
         cfg(($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom));
         pulse_start();
         for (int c = 0; c < 50; c++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) == 0)
               cfg(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom));
            cyc();
         end
         start = 0;
         halt();
      end

      // extreme negative full-length dwell
      din_mode = 0;
      din_fixed = 14'sh2000;
      cfg(16'h0008, 0, 65535, 0);
      clear_q();
      pulse_start();
      run_until_idle(70000);
      check("ext_count", q_ch.size(), 1);
      check("ext_sum", acc_out, -536862720);
      check("ext_ch", acc_ch, 3);

      // asynchronous reset mid-dwell
      din_mode = 2;
      cfg(16'h0102, 1, 50, 1);
      pulse_start();
      repeat (10) cyc();
      #2 rst = 1;
      #1;
      check("arst_sel", sel, 0);
      check("arst_busy", busy, 0);
      check("arst_acc_out", acc_out, 0);
      check("arst_acc_valid", acc_valid, 0);
      check("arst_acc_ch", acc_ch, 0);
      check("arst_scan_done", scan_done, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 0;
      repeat (3) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer for the 16:1 signal-selection muxer of the lock-in datapath.
- Steps the muxer select through a programmable channel mask, with a settle (blanking) interval after each switch and a dwell interval during which the selected muxer output is accumulated.
- Emits one tagged accumulated sum per channel visit; scans single-shot or continuously.
- Sits between the control register bank and the muxer select input; its data input is the muxer output.

Parameters:
- RES, 14, data width of muxer output (signed two's complement)
- DW, 16, dwell counter width; accumulator width is RES+DW
- SW, 8, settle counter width

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin scan (level or pulse; acted on only in IDLE)
- stop  input  1  abort scan
- continuous  input  1  1 = rescan forever, 0 = single pass
- ch_mask  input  16  enabled channels, bit n = muxer input n
- settle_len  input  SW  blanking cycles after each switch
- dwell_len  input  DW  accumulation cycles per channel (0 treated as 1)
- din  input  RES  muxer output (signed)
- sel  output  4  muxer select
- busy  output  1  high in SETTLE or DWELL
- acc_out  output  RES+DW  signed sum of last completed dwell
- acc_valid  output  1  one-cycle strobe, acc_out/acc_ch valid
- acc_ch  output  4  channel of acc_out
- scan_done  output  1  one-cycle strobe at end of each full pass

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - sel=0, busy=0, acc_out=0, acc_valid=0, acc_ch=0, scan_done=0.
  - State IDLE; internal counters and accumulator cleared.
- States: IDLE, SETTLE, DWELL.
- IDLE:
  - On start=1 and stop=0 and ch_mask!=0, latch ch_mask, settle_len, dwell_len (0->1) and continuous.
  - Next cycle: sel = lowest set bit of the latched mask; busy=1; go to SETTLE.
  - start with ch_mask==0 is ignored.
- SETTLE:
  - Remains exactly settle_len cycles, then goes to DWELL.
  - settle_len==0: goes straight to DWELL on the cycle after the switch.
  - Accumulator cleared on entry.
- DWELL:
  - Each cycle, acc += sign-extended din; lasts exactly the latched dwell_len cycles.
  - On the last dwell cycle, the following cycle:
    - acc_valid=1, acc_out = full sum including the last sample, acc_ch = channel just dwelled.
    - sel advances to the next set mask bit strictly above the current one, wrapping to the lowest.
  - A wrap (next index <= current) asserts scan_done in the same cycle as acc_valid.
  - On wrap with continuous=0: go to IDLE, busy=0, sel holds the last channel.
  - Otherwise go to SETTLE for the new channel.
  - Single-bit mask: the channel repeats; every visit is a wrap.
- No overflow is possible: max |sum| fits RES+DW bits for dwell_len <= 2^DW-1.
- stop:
  - In any state, the next cycle is IDLE with busy=0.
  - A partial dwell produces no acc_valid and no scan_done.
  - stop wins over simultaneous start and over a simultaneous dwell completion; sel holds.
- start while busy is ignored; config inputs changing mid-scan have no effect until the next start.
- Reset mid-scan: immediate return to reset values.
- acc_out and acc_ch hold their value between strobes.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SETTLE, DWELL}
  - NCH=16, SELW=4
  - function for dwell_len zero-clamp
- Sub-module next_chan_find: combinational search (16-bit mask, 4-bit current index) -> next index and wrap flag.
- Remaining logic is FSM, counters and accumulator in mux_scan_ctrl.

Test Plan:
- Basic pass:
  - Stimulus: ch_mask=0x0005, settle_len=2, dwell_len=4, continuous=0, din=+3 on sel 0 and -5 on sel 2, start pulse.
  - Response: sel 0 then 2; acc_valid twice with (ch0, +12) then (ch2, -20); scan_done with the second; IDLE with sel=2.
- Zero cases:
  - Stimulus: settle_len=0, dwell_len=0, mask=0x8000, continuous=1.
  - Response: acc_valid every 2 cycles, acc_ch=15, sum = din; scan_done every strobe.
- Wrap order:
  - Stimulus: mask=0x8421, continuous=1.
  - Response: sel sequence 0,5,10,15,0; scan_done only on the 15->0 transition.
- Stop during dwell:
  - Stimulus: stop in the 2nd of 4 dwell cycles.
  - Response: no acc_valid, busy=0 next cycle, sel unchanged; a following start restarts from the lowest set bit.
- Ignored starts:
  - Stimulus: start with ch_mask=0, and start pulses while busy.
  - Response: no state change.
- Extreme values:
  - Stimulus: din=-8192 with dwell_len=65535.
  - Response: acc_out = -536862720 exact; asynchronous rst mid-dwell clears all outputs immediately.
